// File: rtl/float_to_int_pkg.sv
// Shared single-precision constants and the converter state encoding.
package float_to_int_pkg;

    localparam int FLOAT_W    = 32;
    localparam int EXP_W      = 8;
    localparam int MANT_W     = 23;
    localparam int INT_W      = 32;
    localparam int E_W        = 10;
    localparam int FLOAT_BIAS = 127;

    localparam logic [INT_W-1:0] INT_MIN = 32'h8000_0000;

    typedef enum logic [2:0] {
        GET_A,
        UNPACK,
        SPECIAL_CASES,
        CONVERT,
        PUT_Z
    } f2i_state_t;

endpackage

// File: rtl/float_to_int_if.sv
// Operand-in / result-out strobe-acknowledge handshake for the float converter.
interface float_to_int_if;
    import float_to_int_pkg::*;

    logic [FLOAT_W-1:0] input_a;
    logic               input_a_stb;
    logic               input_a_ack;
    logic [INT_W-1:0]   output_z;
    logic               output_z_stb;
    logic               output_z_ack;

    modport slave (
        input  input_a, input_a_stb, output_z_ack,
        output input_a_ack, output_z, output_z_stb
    );

    modport master (
        output input_a, input_a_stb, output_z_ack,
        input  input_a_ack, output_z, output_z_stb
    );

endinterface

// File: rtl/float_to_int.sv
// Iterative IEEE-754 single to signed 32-bit integer converter (truncating).
// state         | meaning
// GET_A         | ready for operand, ack high until captured
// UNPACK        | split captured float into mantissa/exponent/sign
// SPECIAL_CASES | Inf/NaN, |x|<1 and overflow resolved without shifting
// CONVERT       | shift mantissa right one bit per cycle until e == 31
// PUT_Z         | present result, hold until downstream acks
module float_to_int
    import float_to_int_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    float_to_int_if.slave  bus
);

    localparam logic [E_W-1:0]        W_BIAS  = E_W'(FLOAT_BIAS);
    localparam logic signed [E_W-1:0] E_INF   = 10'sd128;
    localparam logic signed [E_W-1:0] E_OVF   = 10'sd30;
    localparam logic signed [E_W-1:0] E_DONE  = 10'sd31;

    f2i_state_t              r_state, w_state_nx;
    logic [FLOAT_W-1:0]      r_a, w_a_nx;
    logic [INT_W-1:0]        r_m, w_m_nx;
    logic signed [E_W-1:0]   r_e, w_e_nx;
    logic                    r_s, w_s_nx;
    logic [INT_W-1:0]        r_z, w_z_nx;
    logic [INT_W-1:0]        r_out, w_out_nx;
    logic                    r_ack, w_ack_nx;
    logic                    r_stb, w_stb_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= GET_A;
            r_a     <= '0;
            r_m     <= '0;
            r_e     <= '0;
            r_s     <= 1'b0;
            r_z     <= '0;
            r_out   <= '0;
            r_ack   <= 1'b0;
            r_stb   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_a     <= w_a_nx;
            r_m     <= w_m_nx;
            r_e     <= w_e_nx;
            r_s     <= w_s_nx;
            r_z     <= w_z_nx;
            r_out   <= w_out_nx;
            r_ack   <= w_ack_nx;
            r_stb   <= w_stb_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_a_nx     = r_a;
        w_m_nx     = r_m;
        w_e_nx     = r_e;
        w_s_nx     = r_s;
        w_z_nx     = r_z;
        w_out_nx   = r_out;
        w_ack_nx   = 1'b0;
        w_stb_nx   = 1'b0;
        case (r_state)
            GET_A: begin
                w_ack_nx = 1'b1;
                if (r_ack && bus.input_a_stb) begin
                    w_a_nx     = bus.input_a;
                    w_ack_nx   = 1'b0;
                    w_state_nx = UNPACK;
                end
            end
            UNPACK: begin
                w_m_nx     = {1'b1, r_a[MANT_W-1:0], 8'b0};
                w_e_nx     = {2'b00, r_a[FLOAT_W-2 -: EXP_W]} - W_BIAS;
                w_s_nx     = r_a[FLOAT_W-1];
                w_state_nx = SPECIAL_CASES;
            end
            SPECIAL_CASES: begin
                if (r_e == E_INF) begin
                    w_z_nx     = INT_MIN;
                    w_state_nx = PUT_Z;
                end else if (r_e[E_W-1]) begin
                    w_z_nx     = '0;
                    w_state_nx = PUT_Z;
                end else if (r_e > E_OVF) begin
                    w_z_nx     = INT_MIN;
                    w_state_nx = PUT_Z;
                end else begin
                    w_state_nx = CONVERT;
                end
            end
            CONVERT: begin
                // mantissa MSB sits at bit 31, so e == 31 means integer bits are aligned
                if (r_e < E_DONE) begin
                    w_m_nx = r_m >> 1;
                    w_e_nx = r_e + 10'sd1;
                end else begin
                    w_z_nx     = r_s ? -r_m : r_m;
                    w_state_nx = PUT_Z;
                end
            end
            PUT_Z: begin
                w_stb_nx = 1'b1;
                w_out_nx = r_z;
                if (r_stb && bus.output_z_ack) begin
                    w_stb_nx   = 1'b0;
                    w_state_nx = GET_A;
                end
            end
            default: w_state_nx = GET_A;
        endcase
    end

    assign bus.input_a_ack  = r_ack;
    assign bus.output_z_stb = r_stb;
    assign bus.output_z     = r_out;

endmodule

// File: tb/tb_float_to_int.sv
// Directed bench for float_to_int: values, latency, backpressure and reset abandonment.
module tb_float_to_int;
    import float_to_int_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    float_to_int_if bus ();

    float_to_int dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.input_a_ack !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_rdy"}, 32'(bus.input_a_ack), 32'd1);
    endtask

    // Drive one operand, capture on edge N, check output value and latency to stb,
    // optionally stall the ack for `hold` cycles, then retire and check the turnaround.
    task automatic xfer(input string tag, input logic [31:0] a, input logic [31:0] exp,
                        input int lat, input int hold);
        int   k = 0;
        logic busy_bad = 1'b0;
        logic hold_bad = 1'b0;
        wait_ready(tag);
        bus.input_a     = a;
        bus.input_a_stb = 1'b1;
        @(posedge clk); #1;
        bus.input_a_stb = 1'b0;
        bus.input_a     = ~a;
        chk({tag, "_ack_drop"}, 32'(bus.input_a_ack), 32'd0);
        while (bus.output_z_stb !== 1'b1 && k < 60) begin
            if (bus.input_a_ack !== 1'b0) busy_bad = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(lat));
        chk({tag, "_val"}, bus.output_z, exp);
        chk({tag, "_busy_ack"}, 32'(busy_bad | bus.input_a_ack), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (bus.output_z !== exp || bus.output_z_stb !== 1'b1 || bus.input_a_ack !== 1'b0)
                hold_bad = 1'b1;
        end
        if (hold > 0) chk({tag, "_hold"}, 32'(hold_bad), 32'd0);
        bus.output_z_ack = 1'b1;
        @(posedge clk); #1;
        bus.output_z_ack = 1'b0;
        chk({tag, "_stb_drop"}, 32'(bus.output_z_stb), 32'd0);
        chk({tag, "_ack_late"}, 32'(bus.input_a_ack), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_ack_rise"}, 32'(bus.input_a_ack), 32'd1);
    endtask

    initial begin
        int   k;
        logic stb_seen;
        bus.input_a      = '0;
        bus.input_a_stb  = 1'b0;
        bus.output_z_ack = 1'b0;

        #1;
        chk("rst_ack", 32'(bus.input_a_ack), 32'd0);
        chk("rst_stb", 32'(bus.output_z_stb), 32'd0);
        chk("rst_z", bus.output_z, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("rst_ack_held", 32'(bus.input_a_ack), 32'd0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ack_first_edge", 32'(bus.input_a_ack), 32'd1);

        xfer("one",      32'h3F80_0000, 32'h0000_0001, 35, 0);
        xfer("m2p5",     32'hC020_0000, 32'hFFFF_FFFE, 34, 0);
        xfer("p075",     32'h3F40_0000, 32'h0000_0000,  3, 0);
        xfer("denorm",   32'h0000_0001, 32'h0000_0000,  3, 0);
        xfer("max_fit",  32'h4EFF_FFFF, 32'h7FFF_FF80,  5, 0);
        xfer("two31",    32'h4F00_0000, 32'h8000_0000,  3, 0);
        xfer("m_two31",  32'hCF00_0000, 32'h8000_0000,  3, 0);
        xfer("nan",      32'h7FC0_0000, 32'h8000_0000,  3, 0);
        xfer("minf",     32'hFF80_0000, 32'h8000_0000,  3, 0);
        xfer("bp",       32'hC020_0000, 32'hFFFF_FFFE, 34, 20);

        // reset mid-convert: previous output_z is nonzero, so clearing is observable
        wait_ready("rcv");
        bus.input_a     = 32'h3F80_0000;
        bus.input_a_stb = 1'b1;
        @(posedge clk); #1;
        bus.input_a_stb = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rcv_stb", 32'(bus.output_z_stb), 32'd0);
        chk("rcv_ack", 32'(bus.input_a_ack), 32'd0);
        chk("rcv_z", bus.output_z, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("rcv_ack_rise", 32'(bus.input_a_ack), 32'd1);
        stb_seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.output_z_stb !== 1'b0) stb_seen = 1'b1;
        end
        chk("rcv_no_stb", 32'(stb_seen), 32'd0);
        xfer("ten", 32'h4120_0000, 32'h0000_000A, 32, 0);

        // reset while result is presented under backpressure
        wait_ready("rpz");
        bus.input_a     = 32'hC020_0000;
        bus.input_a_stb = 1'b1;
        @(posedge clk); #1;
        bus.input_a_stb = 1'b0;
        k = 0;
        while (bus.output_z_stb !== 1'b1 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("rpz_val", bus.output_z, 32'hFFFF_FFFE);
        #2 rst = 1'b0;
        #1;
        chk("rpz_stb", 32'(bus.output_z_stb), 32'd0);
        chk("rpz_z", bus.output_z, 32'd0);
        @(negedge clk) rst = 1'b1;
        xfer("after_rpz", 32'h3F80_0000, 32'h0000_0001, 35, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
